// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   load_state_t   : loader FSM states
//   WORD_BYTES     : bytes per instruction word
//   IMEM_BASE      : default byte address of the first written word
//   MAX_WORDS_DEF  : default largest accepted image length in words
//   state_accepts(): 1 for the states in which a byte may be taken
package mips_pkg;

  localparam int          WORD_BYTES    = 4;
  localparam logic [31:0] IMEM_BASE     = 32'h0000_0000;
  localparam int          MAX_WORDS_DEF = 256;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } load_state_t;

  function automatic logic state_accepts(load_state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
//   rx_valid   : byte source has a byte
//   rx_data    : byte value
//   rx_ready   : loader takes the byte this cycle
//   imem_we    : one-cycle write strobe per word
//   imem_addr  : word-aligned byte address of the write
//   imem_wdata : word to write
// slave  : the loader (consumes bytes, produces writes)
// master : the environment (byte source + instruction memory)
interface imem_boot_loader_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/byte_to_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream.
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   byte_valid : shift byte_data in this cycle
//   byte_data  : incoming byte
//   word       : current shift register contents (first byte ends in [31:24])
//   word_valid : combinational, high on the cycle the 4th byte of a word is shifted
module byte_to_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] shift_q;
  logic [1:0]  cnt_q;

  // The counter wraps after every 4th byte, so a new word always starts aligned.
  assign word_valid = byte_valid && (cnt_q == 2'd3);
  assign word       = shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= 32'h0;
      cnt_q   <= 2'd0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[23:0], byte_data};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Fills instruction memory from a length-prefixed big-endian byte stream and
// holds the CPU in reset until the image is complete.
// Ports:
//   CLOCK_50     : system clock, rising edge
//   reset        : synchronous, active-high
//   bus          : imem_boot_loader_if.slave (byte stream in, imem writes out)
//   cpu_hold     : keeps the CPU/PC in reset while high
//   load_done    : image loaded, sticky until reset
//   load_err     : protocol error, sticky until reset
//   words_loaded : words written so far
// Build option: IMEM_BOOT_CHECKSUM_EN adds a trailing checksum byte; the 8-bit
// sum of every transferred byte (header, data, checksum) must be zero.
//
// state    | meaning
// S_LEN_HI | waiting for length high byte
// S_LEN_LO | waiting for length low byte, range check
// S_DATA   | collecting the 4 bytes of a word
// S_WRITE  | one-cycle imem write strobe, rx_ready low
// S_CSUM   | waiting for checksum byte (checksum build only)
// S_DONE   | image loaded, CPU released
// S_ERR    | protocol error, CPU held
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE,
  parameter int          MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [15:0]         words_loaded
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam load_state_t S_END = S_CSUM;
`else
  localparam load_state_t S_END = S_DONE;
`endif

  load_state_t state_q, state_d;
  logic        rx_ready_q;
  logic [15:0] length_q, length_d;
  logic [15:0] words_q;
  logic        xfer;
  logic        pack_valid;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len_full;
  logic        last_word;

  assign xfer       = bus.rx_valid && rx_ready_q;
  assign pack_valid = xfer && (state_q == S_DATA);
  assign len_full   = {length_q[15:8], bus.rx_data};
  assign last_word  = ((words_q + 16'd1) == length_q);

  byte_to_word_packer u_packer (
    .clk        (CLOCK_50),
    .reset      (reset),
    .byte_valid (pack_valid),
    .byte_data  (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_next;

  assign sum_next = sum_q + bus.rx_data;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sum_q <= 8'h00;
    end else if (xfer) begin
      sum_q <= sum_next;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          length_d[15:8] = bus.rx_data;
          state_d        = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          length_d[7:0] = bus.rx_data;
          if (len_full > MAX_LEN) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_END;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_valid) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = last_word ? S_END : S_DATA;
      end
      S_CSUM: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (xfer) begin
          state_d = (sum_next == 8'h00) ? S_DONE : S_ERR;
        end
`else
        state_d = S_ERR;
`endif
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // rx_ready is registered from the next state so it always matches the state
  // it is seen with, except for the single cycle right after reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_LEN_HI;
      rx_ready_q <= 1'b0;
      length_q   <= 16'd0;
      words_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= state_accepts(state_d);
      length_q   <= length_d;
      if (state_q == S_WRITE) begin
        words_q <= words_q + 16'd1;
      end
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = BASE_ADDR + {14'd0, words_q, 2'b00};
  assign bus.imem_wdata = word;

  assign cpu_hold     = (state_q != S_DONE);
  assign load_done    = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and randomized byte
// streams, checked against a stream-level reference model.
module tb_imem_boot_loader;

  localparam int          MAX_W = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  imem_boot_loader_if bus ();

  imem_boot_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAX_W)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  logic [7:0]  stream[$];
  int          xfer_cyc[$];
  logic [31:0] w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  int          flag_cyc = -1;

  always @(negedge CLOCK_50) begin
    if (bus.imem_we) begin
      w_addr.push_back(bus.imem_addr);
      w_data.push_back(bus.imem_wdata);
      w_cyc.push_back(cyc);
    end
    if ((load_done || load_err) && flag_cyc < 0) flag_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    xfer_cyc.delete();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    flag_cyc = -1;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  // Appends the byte that makes the 8-bit sum of the whole stream zero.
  task automatic add_csum(input bit corrupt);
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    foreach (stream[i]) s = s + stream[i];
    stream.push_back(8'h00 - s + (corrupt ? 8'h01 : 8'h00));
`else
    if (corrupt) stream.push_back(8'h00);
`endif
  endtask

  task automatic make_stream(input int len);
    stream.delete();
    stream.push_back(8'(len >> 8));
    stream.push_back(8'(len));
    if (len <= MAX_W) begin
      for (int k = 0; k < len; k++) push_word($urandom);
      add_csum(1'b0);
    end
  endtask

  task automatic drive(input int gap_pct);
    int idx;
    int t;
    int budget;
    idx    = 0;
    t      = 0;
    budget = 20 * stream.size() + 100;
    @(posedge CLOCK_50);
    #1;
    while (idx < stream.size() && t < budget) begin
      bus.rx_valid = ($urandom_range(99) >= gap_pct);
      bus.rx_data  = bus.rx_valid ? stream[idx] : 8'($urandom);
      @(negedge CLOCK_50);
      if (bus.rx_valid && bus.rx_ready) begin
        xfer_cyc.push_back(cyc);
        idx++;
      end
      @(posedge CLOCK_50);
      #1;
      t++;
    end
    bus.rx_valid = 1'b0;
    chk("bytes_taken", 32'(idx), 32'(stream.size()));
  endtask

  // Reference model: expected writes, final flags and flag timing derived
  // directly from the byte stream.
  task automatic check_run(input string name);
    int len;
    int n_exp;
    int lat;
    int b;
    bit exp_err;
    logic [7:0] s;
    repeat (4) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    len     = int'({stream[0], stream[1]});
    exp_err = (len > MAX_W);
    n_exp   = exp_err ? 0 : len;
`ifdef IMEM_BOOT_CHECKSUM_EN
    s = 8'h00;
    foreach (stream[i]) s = s + stream[i];
    if (!exp_err) exp_err = (s != 8'h00);
    lat = 1;
`else
    s   = 8'h00;
    lat = (len > MAX_W || len == 0) ? 1 : 2;
`endif
    chk({name, ".n_writes"}, 32'(w_addr.size()), 32'(n_exp));
    for (int k = 0; k < n_exp && k < w_addr.size(); k++) begin
      b = 2 + 4 * k;
      chk({name, ".addr"}, w_addr[k], BASE + 32'(4 * k));
      chk({name, ".data"}, w_data[k], {stream[b], stream[b+1], stream[b+2], stream[b+3]});
      if (b + 3 < xfer_cyc.size())
        chk({name, ".wr_latency"}, 32'(w_cyc[k]), 32'(xfer_cyc[b+3] + 1));
    end
    chk({name, ".load_done"}, 32'(load_done), 32'(!exp_err));
    chk({name, ".load_err"}, 32'(load_err), 32'(exp_err));
    chk({name, ".cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
    chk({name, ".rx_ready"}, 32'(bus.rx_ready), 32'h0);
    chk({name, ".words_loaded"}, 32'(words_loaded), 32'(n_exp));
    if (xfer_cyc.size() > 0)
      chk({name, ".flag_cycle"}, 32'(flag_cyc), 32'(xfer_cyc[xfer_cyc.size()-1] + lat));
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset values
    reset = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst.rx_ready", 32'(bus.rx_ready), 32'h0);
    chk("rst.imem_we", 32'(bus.imem_we), 32'h0);
    chk("rst.imem_addr", bus.imem_addr, BASE);
    chk("rst.imem_wdata", bus.imem_wdata, 32'h0);
    chk("rst.cpu_hold", 32'(cpu_hold), 32'h1);
    chk("rst.load_done", 32'(load_done), 32'h0);
    chk("rst.load_err", 32'(load_err), 32'h0);
    chk("rst.words_loaded", 32'(words_loaded), 32'h0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rst.rx_ready_release", 32'(bus.rx_ready), 32'h0);
    @(negedge CLOCK_50);
    chk("rst.rx_ready_after", 32'(bus.rx_ready), 32'h1);
    clear_obs();

    // Two words, no gaps, then extra bytes after completion are ignored
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h02);
    push_word(32'h2008_0005);
    push_word(32'h0000_0008);
    add_csum(1'b0);
    drive(0);
    check_run("two_words");
    bus.rx_valid = 1'b1;
    repeat (6) begin
      bus.rx_data = 8'($urandom);
      @(posedge CLOCK_50);
      #1;
    end
    bus.rx_valid = 1'b0;
    @(negedge CLOCK_50);
    chk("extra.n_writes", 32'(w_addr.size()), 32'd2);
    chk("extra.words_loaded", 32'(words_loaded), 32'd2);
    chk("extra.load_done", 32'(load_done), 32'h1);

    // Length one above the limit
    do_reset();
    make_stream(257);
    drive(0);
    check_run("len_257");

    // Empty image
    do_reset();
    make_stream(0);
    drive(0);
    check_run("len_0");

    // Three words with random source gaps
    do_reset();
    make_stream(3);
    drive(50);
    check_run("gappy_3");

    // Reset after two data bytes, then a fresh one-word stream
    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h01);
    stream.push_back(8'hAA);
    stream.push_back(8'hBB);
    drive(0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("midrst.cpu_hold", 32'(cpu_hold), 32'h1);
    do_reset();
    @(negedge CLOCK_50);
    chk("midrst.words_loaded", 32'(words_loaded), 32'h0);
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h01);
    push_word(32'hAABB_CCDD);
    add_csum(1'b0);
    drive(0);
    check_run("midrst_reload");

    // Largest accepted image
    do_reset();
    make_stream(MAX_W);
    drive(0);
    check_run("len_max");

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Bad checksum
    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h01);
    push_word(32'h0102_0304);
    add_csum(1'b1);
    drive(0);
    check_run("bad_csum");
`endif

    // Randomized lengths and gap rates
    for (int r = 0; r < 8; r++) begin
      do_reset();
      if (r == 7) make_stream(int'($urandom_range(MAX_W + 1, 65535)));
      else        make_stream(int'($urandom_range(0, 6)));
      drive(int'($urandom_range(0, 60)));
      check_run("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
